// File: rtl/cfg_routing_mux_pkg.sv
// Shared routing definitions: default mux geometry used by the RTL and the config-bitstream
// generator, plus a constant-friendly ceiling log2.
package routing_pkg;

    localparam int DEFAULT_SEL    = 4;
    localparam int DEFAULT_INPUTS = 16;
    localparam int DEFAULT_WIDTH  = 1;

    function automatic int clog2(input int value);
        int result;
        int remaining;
        result    = 0;
        remaining = value - 1;
        while (remaining > 0) begin
            result    = result + 1;
            remaining = remaining >> 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/cfg_routing_mux_shift_reg.sv
// N-bit serial configuration chain with enable, parallel view and registered serial tail.
// Shared between routing muxes and LUT config cells.
module cfg_shift_reg #(
    parameter int N = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         shift_en,
    input  logic         serial_in,
    output logic [N-1:0] parallel_out,
    output logic         serial_out
);

    logic [N-1:0] chain;

    generate
        if (N == 1) begin : g_single
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n)        chain <= '0;
                else if (shift_en) chain <= serial_in;
            end
        end else begin : g_multi
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n)        chain <= '0;
                else if (shift_en) chain <= {chain[N-2:0], serial_in};
            end
        end
    endgenerate

    assign parallel_out = chain;
    assign serial_out   = chain[N-1];

endmodule

// File: rtl/cfg_routing_mux.sv
// Routing mux whose select is loaded through a serial config chain and committed to a
// shadow register on cfg_latch, so the routed path never changes while the chain loads.
module cfg_routing_mux
    import routing_pkg::*;
#(
    parameter int SEL        = DEFAULT_SEL,
    parameter int INPUTS     = DEFAULT_INPUTS,
    parameter int WIDTH      = DEFAULT_WIDTH,
    parameter bit REGISTERED = 1'b1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    cfg_en,
    input  logic                    cfg_in,
    input  logic                    cfg_latch,
    output logic                    cfg_out,
    input  logic [INPUTS*WIDTH-1:0] data_in,
    output logic [WIDTH-1:0]        data_out,
    output logic                    cfg_valid,
    output logic                    sel_err
);

    localparam int NUM_SLOTS = 1 << SEL;

    logic [SEL-1:0]   chain;
    logic [SEL-1:0]   active_sel;
    logic [WIDTH-1:0] slots [NUM_SLOTS];
    logic [WIDTH-1:0] routed;

    cfg_shift_reg #(.N(SEL)) u_chain (
        .clk          (clk),
        .rst_n        (rst_n),
        .shift_en     (cfg_en),
        .serial_in    (cfg_in),
        .parallel_out (chain),
        .serial_out   (cfg_out)
    );

    // Latch samples the chain before any same-cycle shift lands, by nonblocking semantics.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            active_sel <= '0;
            cfg_valid  <= 1'b0;
        end else if (cfg_latch) begin
            active_sel <= chain;
            cfg_valid  <= 1'b1;
        end
    end

    generate
        if (INPUTS < NUM_SLOTS) begin : g_range_check
            localparam logic [SEL:0] INPUTS_W = (SEL+1)'(INPUTS);
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n)         sel_err <= 1'b0;
                else if (cfg_latch) sel_err <= ({1'b0, chain} >= INPUTS_W);
            end
        end else begin : g_full_range
            assign sel_err = 1'b0;
        end
    endgenerate

    // Unpopulated select codes map to zero slots so the index is always in range.
    generate
        for (genvar i = 0; i < NUM_SLOTS; i++) begin : g_slots
            if (i < INPUTS) begin : g_used
                assign slots[i] = data_in[i*WIDTH +: WIDTH];
            end else begin : g_unused
                assign slots[i] = '0;
            end
        end
    endgenerate

    assign routed = sel_err ? '0 : slots[active_sel];

    generate
        if (REGISTERED) begin : g_reg_out
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) data_out <= '0;
                else        data_out <= routed;
            end
        end else begin : g_comb_out
            assign data_out = routed;
        end
    endgenerate

endmodule

// File: tb/tb_cfg_routing_mux.sv
// Directed bench for cfg_routing_mux: registered, combinational, short-range and daisy-chained
// instances driven from shared config strobes, each scenario checked in its own task.
module tb_cfg_routing_mux;

    logic         clk = 1'b0;
    logic         rst_n, cfg_en, cfg_in, cfg_latch;
    logic [127:0] data_in;
    logic [7:0]   m_out, c_out, o_out;
    logic         m_cfg_out, m_valid, m_err;
    logic         c_cfg_out, c_valid, c_err;
    logic         o_cfg_out, o_valid, o_err;
    logic         d_en, d_in, d_latch, link, tail_cfg_out;
    logic [15:0]  head_data, tail_data;
    logic [0:0]   head_out, tail_out;
    logic         head_valid, tail_valid, head_err, tail_err;
    int           compared = 0;
    int           mismatched = 0;

    always #5 clk = ~clk;

    cfg_routing_mux #(.SEL(4), .INPUTS(16), .WIDTH(8), .REGISTERED(1'b1)) dut_main (
        .clk(clk), .rst_n(rst_n), .cfg_en(cfg_en), .cfg_in(cfg_in), .cfg_latch(cfg_latch),
        .cfg_out(m_cfg_out), .data_in(data_in), .data_out(m_out), .cfg_valid(m_valid), .sel_err(m_err));

    cfg_routing_mux #(.SEL(4), .INPUTS(16), .WIDTH(8), .REGISTERED(1'b0)) dut_comb (
        .clk(clk), .rst_n(rst_n), .cfg_en(cfg_en), .cfg_in(cfg_in), .cfg_latch(cfg_latch),
        .cfg_out(c_cfg_out), .data_in(data_in), .data_out(c_out), .cfg_valid(c_valid), .sel_err(c_err));

    cfg_routing_mux #(.SEL(4), .INPUTS(12), .WIDTH(8), .REGISTERED(1'b1)) dut_oor (
        .clk(clk), .rst_n(rst_n), .cfg_en(cfg_en), .cfg_in(cfg_in), .cfg_latch(cfg_latch),
        .cfg_out(o_cfg_out), .data_in(data_in[95:0]), .data_out(o_out), .cfg_valid(o_valid), .sel_err(o_err));

    cfg_routing_mux #(.SEL(4), .INPUTS(16), .WIDTH(1), .REGISTERED(1'b1)) dut_head (
        .clk(clk), .rst_n(rst_n), .cfg_en(d_en), .cfg_in(d_in), .cfg_latch(d_latch),
        .cfg_out(link), .data_in(head_data), .data_out(head_out), .cfg_valid(head_valid), .sel_err(head_err));

    cfg_routing_mux #(.SEL(4), .INPUTS(16), .WIDTH(1), .REGISTERED(1'b1)) dut_tail (
        .clk(clk), .rst_n(rst_n), .cfg_en(d_en), .cfg_in(link), .cfg_latch(d_latch),
        .cfg_out(tail_cfg_out), .data_in(tail_data), .data_out(tail_out), .cfg_valid(tail_valid), .sel_err(tail_err));

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic shift_main(input logic [3:0] bits);
        for (int i = 3; i >= 0; i--) begin
            cfg_en = 1'b1;
            cfg_in = bits[i];
            tick();
        end
        cfg_en = 1'b0;
        cfg_in = 1'b0;
    endtask

    task automatic latch_main();
        cfg_latch = 1'b1;
        tick();
        cfg_latch = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #2;
        compared++; if (m_out !== 8'h00) begin mismatched++; $display("[TB] FAIL reset_main_out: got %h expected 00", m_out); end
        compared++; if ({m_valid, m_err, m_cfg_out} !== 3'b000) begin mismatched++; $display("[TB] FAIL reset_main_flags: got %b expected 000", {m_valid, m_err, m_cfg_out}); end
        compared++; if ({o_valid, o_err, o_cfg_out, c_valid, c_cfg_out} !== 5'b00000) begin mismatched++; $display("[TB] FAIL reset_other_flags: got %b expected 00000", {o_valid, o_err, o_cfg_out, c_valid, c_cfg_out}); end
        compared++; if (c_out !== 8'h5A) begin mismatched++; $display("[TB] FAIL reset_comb_ch0: got %h expected 5a", c_out); end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_cfg_out_timing();
        for (int i = 0; i < 3; i++) begin
            cfg_en = 1'b1;
            cfg_in = (i == 0);
            tick();
        end
        compared++; if (m_cfg_out !== 1'b0) begin mismatched++; $display("[TB] FAIL cfg_out_after3: got %b expected 0", m_cfg_out); end
        cfg_in = 1'b0;
        tick();
        compared++; if (m_cfg_out !== 1'b1) begin mismatched++; $display("[TB] FAIL cfg_out_after4: got %b expected 1", m_cfg_out); end
        cfg_en = 1'b0;
        tick();
        compared++; if (m_cfg_out !== 1'b1) begin mismatched++; $display("[TB] FAIL cfg_out_hold: got %b expected 1", m_cfg_out); end
        cfg_en = 1'b1;
        tick();
        cfg_en = 1'b0;
        compared++; if (m_cfg_out !== 1'b0) begin mismatched++; $display("[TB] FAIL cfg_out_push: got %b expected 0", m_cfg_out); end
    endtask

    task automatic test_load_route();
        shift_main(4'b1010);
        latch_main();
        compared++; if (m_valid !== 1'b1 || m_err !== 1'b0) begin mismatched++; $display("[TB] FAIL load_flags: got valid=%b err=%b expected 1 0", m_valid, m_err); end
        compared++; if (c_out !== 8'hA5) begin mismatched++; $display("[TB] FAIL comb_zero_latency: got %h expected a5", c_out); end
        compared++; if (m_out !== 8'h5A) begin mismatched++; $display("[TB] FAIL reg_latency: got %h expected 5a", m_out); end
        tick();
        compared++; if (m_out !== 8'hA5) begin mismatched++; $display("[TB] FAIL route_ch10: got %h expected a5", m_out); end
        data_in[80 +: 8] = 8'hC3;
        tick();
        compared++; if (m_out !== 8'hC3) begin mismatched++; $display("[TB] FAIL data_follow: got %h expected c3", m_out); end
        data_in[80 +: 8] = 8'hA5;
        tick();
    endtask

    task automatic test_no_glitch();
        for (int i = 3; i >= 0; i--) begin
            cfg_en = 1'b1;
            cfg_in = (i < 2);
            tick();
            compared++; if (m_out !== 8'hA5) begin mismatched++; $display("[TB] FAIL no_glitch_shift%0d: got %h expected a5", 3 - i, m_out); end
        end
        cfg_en = 1'b0;
        latch_main();
        compared++; if (m_out !== 8'hA5) begin mismatched++; $display("[TB] FAIL no_glitch_latch_edge: got %h expected a5", m_out); end
        tick();
        compared++; if (m_out !== 8'h33) begin mismatched++; $display("[TB] FAIL switch_ch3: got %h expected 33", m_out); end
    endtask

    task automatic test_simultaneous();
        shift_main(4'b0101);
        cfg_en = 1'b1;
        cfg_in = 1'b1;
        cfg_latch = 1'b1;
        tick();
        cfg_en = 1'b0;
        cfg_in = 1'b0;
        cfg_latch = 1'b0;
        compared++; if (c_out !== 8'h55) begin mismatched++; $display("[TB] FAIL simul_pre_shift: got %h expected 55", c_out); end
        tick();
        compared++; if (m_out !== 8'h55) begin mismatched++; $display("[TB] FAIL simul_main_ch5: got %h expected 55", m_out); end
        latch_main();
        tick();
        compared++; if (m_out !== 8'hBB) begin mismatched++; $display("[TB] FAIL simul_chain_1011: got %h expected bb", m_out); end
    endtask

    task automatic test_out_of_range();
        shift_main(4'b1110);
        latch_main();
        compared++; if (o_err !== 1'b1 || m_err !== 1'b0) begin mismatched++; $display("[TB] FAIL oor_err14: got oor=%b main=%b expected 1 0", o_err, m_err); end
        tick();
        compared++; if (o_out !== 8'h00) begin mismatched++; $display("[TB] FAIL oor_zero_out: got %h expected 00", o_out); end
        compared++; if (m_out !== 8'hEE) begin mismatched++; $display("[TB] FAIL main_ch14: got %h expected ee", m_out); end
        shift_main(4'b0100);
        latch_main();
        compared++; if (o_err !== 1'b0) begin mismatched++; $display("[TB] FAIL oor_clear4: got %b expected 0", o_err); end
        tick();
        compared++; if (o_out !== 8'h44) begin mismatched++; $display("[TB] FAIL oor_ch4: got %h expected 44", o_out); end
        shift_main(4'b1011);
        latch_main();
        tick();
        compared++; if (o_err !== 1'b0 || o_out !== 8'hBB) begin mismatched++; $display("[TB] FAIL oor_edge11: got err=%b out=%h expected 0 bb", o_err, o_out); end
        shift_main(4'b1100);
        latch_main();
        tick();
        compared++; if (o_err !== 1'b1 || o_out !== 8'h00) begin mismatched++; $display("[TB] FAIL oor_edge12: got err=%b out=%h expected 1 00", o_err, o_out); end
    endtask

    task automatic test_daisy_chain();
        logic [7:0] stream;
        stream = 8'h3C;
        head_data = 16'h1000;
        tail_data = 16'h0008;
        for (int i = 7; i >= 0; i--) begin
            d_en = 1'b1;
            d_in = stream[i];
            tick();
        end
        d_en = 1'b0;
        d_in = 1'b0;
        d_latch = 1'b1;
        tick();
        d_latch = 1'b0;
        tick();
        compared++; if (head_out !== 1'b1) begin mismatched++; $display("[TB] FAIL daisy_head_sel12: got %b expected 1", head_out); end
        compared++; if (tail_out !== 1'b1) begin mismatched++; $display("[TB] FAIL daisy_tail_sel3: got %b expected 1", tail_out); end
        compared++; if ({head_valid, tail_valid, head_err, tail_err, tail_cfg_out} !== 5'b11000) begin mismatched++; $display("[TB] FAIL daisy_flags: got %b expected 11000", {head_valid, tail_valid, head_err, tail_err, tail_cfg_out}); end
        head_data = ~16'h1000;
        tail_data = ~16'h0008;
        tick();
        compared++; if ({head_out, tail_out} !== 2'b00) begin mismatched++; $display("[TB] FAIL daisy_inverse: got %b expected 00", {head_out, tail_out}); end
    endtask

    task automatic test_reset_mid();
        cfg_en = 1'b1;
        cfg_in = 1'b1;
        tick();
        compared++; if (m_cfg_out !== 1'b1) begin mismatched++; $display("[TB] FAIL mid_pre_cfg_out: got %b expected 1", m_cfg_out); end
        #2;
        rst_n = 1'b0;
        #1;
        compared++; if (m_out !== 8'h00 || m_valid !== 1'b0 || m_cfg_out !== 1'b0) begin mismatched++; $display("[TB] FAIL mid_reset_main: got out=%h valid=%b cfg_out=%b expected 00 0 0", m_out, m_valid, m_cfg_out); end
        compared++; if (o_err !== 1'b0 || o_valid !== 1'b0) begin mismatched++; $display("[TB] FAIL mid_reset_oor: got err=%b valid=%b expected 0 0", o_err, o_valid); end
        cfg_en = 1'b0;
        cfg_in = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        latch_main();
        tick();
        compared++; if (m_out !== 8'h5A || m_valid !== 1'b1) begin mismatched++; $display("[TB] FAIL post_reset_ch0: got out=%h valid=%b expected 5a 1", m_out, m_valid); end
    endtask

    initial begin
        cfg_en = 1'b0; cfg_in = 1'b0; cfg_latch = 1'b0;
        d_en = 1'b0; d_in = 1'b0; d_latch = 1'b0;
        head_data = '0; tail_data = '0;
        for (int i = 0; i < 16; i++) data_in[i*8 +: 8] = 8'(i * 17);
        data_in[7:0]   = 8'h5A;
        data_in[80 +: 8] = 8'hA5;
        test_reset();
        test_cfg_out_timing();
        test_load_route();
        test_no_glitch();
        test_simultaneous();
        test_out_of_range();
        test_daisy_chain();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
